// File: rtl/pwm_cfg_arbiter_if.sv
// Write-request bus shared by the SPI command decoder (A) and the config sequencer (B).
// The master drives requests; the slave (pwm_cfg_arbiter) returns per-requester ready.
interface pwm_cfg_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/pwm_cfg_arbiter.sv
// PWM configuration register block: round-robin write arbiter between two requesters.
// PWM_CFG_SHADOW_EN: when defined, writes go to shadow copies committed on commit_strobe.
module pwm_cfg_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_cfg_arbiter_if.slave    req,
  input  logic                commit_strobe,
  output logic [DATA_W-1:0]   en_reg_out_7_0,
  output logic [DATA_W-1:0]   en_reg_out_15_8,
  output logic [DATA_W-1:0]   en_reg_pwm_7_0,
  output logic [DATA_W-1:0]   en_reg_pwm_15_8,
  output logic [DATA_W-1:0]   pwm_duty_cycle,
  output logic [NUM_REGS-1:0] pending,
  output logic                err_addr
);

  typedef enum logic {IDLE, WR} state_t;

  state_t              state;
  logic                rr_b;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                grant_a;
  logic                grant_b;
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0]   active [NUM_REGS];

  // Ready is decoded from state and qualified by rst_n so it drops the instant reset asserts.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req.a_valid && (!req.b_valid || rr_b))
        grant_a = 1'b1;
      else if (req.b_valid)
        grant_b = 1'b1;
    end
  end

  assign req.a_ready = grant_a;
  assign req.b_ready = grant_b;

  // Full ADDR_W compare per register: out-of-range addresses hit nothing, so no aliasing.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      wr_hit[i] = (state == WR) && (wr_addr == ADDR_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_b     <= 1'b1;
      wr_addr  <= '0;
      wr_data  <= '0;
      err_addr <= 1'b0;
    end else begin
      err_addr <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            wr_addr <= grant_a ? req.a_addr : req.b_addr;
            wr_data <= grant_a ? req.a_data : req.b_data;
            rr_b    <= grant_b;
            state   <= WR;
          end
        end
        WR: begin
          err_addr <= ~|wr_hit;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_CFG_SHADOW_EN
  logic [DATA_W-1:0]   shadow [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;

  // Commit reads the pre-write shadow; a same-edge write re-arms pending for the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit_strobe && pending_q[i]) begin
          active[i]    <= shadow[i];
          pending_q[i] <= 1'b0;
        end
        if (wr_hit[i]) begin
          shadow[i]    <= wr_data;
          pending_q[i] <= 1'b1;
        end
      end
    end
  end

  assign pending = pending_q;
`else
  logic unused_commit_strobe;
  assign unused_commit_strobe = commit_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        active[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (wr_hit[i])
          active[i] <= wr_data;
    end
  end

  assign pending = '0;
`endif

  assign en_reg_out_7_0  = active[0];
  assign en_reg_out_15_8 = active[1];
  assign en_reg_pwm_7_0  = active[2];
  assign en_reg_pwm_15_8 = active[3];
  assign pwm_duty_cycle  = active[4];

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed, table-driven bench for pwm_cfg_arbiter; expectations follow PWM_CFG_SHADOW_EN.
module tb_pwm_cfg_arbiter;

`ifdef PWM_CFG_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       commit_strobe = 1'b0;
  logic [7:0] r0, r1, r2, r3, r4;
  logic [4:0] pending;
  logic       err_addr;

  int checks = 0;
  int failures = 0;

  pwm_cfg_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  pwm_cfg_arbiter #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (bus),
    .commit_strobe   (commit_strobe),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .pending         (pending),
    .err_addr        (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [6:0] aa;
    logic [7:0] ad;
    logic       bv;
    logic [6:0] ba;
    logic [7:0] bd;
    logic       cs;
    logic       e_ar;
    logic       e_br;
    logic       e_err;
    logic [4:0] e_pend;
    logic [39:0] e_act;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [39:0] pk(input logic [7:0] v4, input logic [7:0] v3,
                                     input logic [7:0] v2, input logic [7:0] v1,
                                     input logic [7:0] v0);
    return {v4, v3, v2, v1, v0};
  endfunction

  function automatic vec_t mk(input logic av, input logic [6:0] aa, input logic [7:0] ad,
                              input logic bv, input logic [6:0] ba, input logic [7:0] bd,
                              input logic cs, input logic e_ar, input logic e_br,
                              input logic e_err, input logic [4:0] e_pend,
                              input logic [39:0] e_act);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.cs = cs;
    v.e_ar = e_ar; v.e_br = e_br; v.e_err = e_err; v.e_pend = e_pend; v.e_act = e_act;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
    bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
    commit_strobe = v.cs;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d a_ready", idx), 64'(bus.a_ready), 64'(v.e_ar));
    chk($sformatf("v%0d b_ready", idx), 64'(bus.b_ready), 64'(v.e_br));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d err_addr", idx), 64'(err_addr), 64'(v.e_err));
    chk($sformatf("v%0d pending", idx), 64'(pending), 64'(v.e_pend));
    chk($sformatf("v%0d active", idx), 64'({r4, r3, r2, r1, r0}), 64'(v.e_act));
  endtask

  initial begin
    vec_t idle;
    logic [39:0] act_sh, act_ns, act_e;
    logic [4:0]  pend_e;
    idle = mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 0, 5'h00, 40'h0);
    drive(idle);

    // Tie from reset: A wins, B follows; B's value lands last in register 0.
    vecs.push_back(mk(1, 7'h00, 8'hAA, 1, 7'h00, 8'h55, 0, 1, 0, 0, 5'h00, pk(0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 1, 7'h00, 8'h55, 0, 0, 0, 0,
                      SH ? 5'h01 : 5'h00, SH ? pk(0, 0, 0, 0, 0) : pk(0, 0, 0, 0, 8'hAA)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 1, 7'h00, 8'h55, 0, 0, 1, 0,
                      SH ? 5'h01 : 5'h00, SH ? pk(0, 0, 0, 0, 0) : pk(0, 0, 0, 0, 8'hAA)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 0,
                      SH ? 5'h01 : 5'h00, SH ? pk(0, 0, 0, 0, 0) : pk(0, 0, 0, 0, 8'h55)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0, 0, 5'h00, pk(0, 0, 0, 0, 8'h55)));

    // Continuous dual requests, four writes each: A -> reg1 (11..14), B -> reg3 (21..24).
    for (int k = 0; k < 16; k++) begin
      int abefore, bbefore, acnt, bcnt;
      abefore = (k + 3) / 4;
      bbefore = (k + 1) / 4;
      acnt    = (k + 3) / 4;
      bcnt    = (k + 1) / 4;
      act_ns = pk(0, (bcnt != 0) ? 8'(8'h20 + bcnt) : 8'h00, 0,
                  (acnt != 0) ? 8'(8'h10 + acnt) : 8'h00, 8'h55);
      act_sh = pk(0, 0, 0, 0, 8'h55);
      pend_e = SH ? {1'b0, bcnt != 0, 1'b0, acnt != 0, 1'b0} : 5'h00;
      vecs.push_back(mk(abefore < 4, 7'h01, 8'(8'h11 + abefore),
                        bbefore < 4, 7'h03, 8'(8'h21 + bbefore), 0,
                        (k % 4) == 0, (k % 4) == 2, 0, pend_e, SH ? act_sh : act_ns));
    end

    // Out-of-range addresses (7, and 0x44 which must not alias reg 4) raise err_addr only.
    act_e  = SH ? pk(0, 0, 0, 0, 8'h55) : pk(0, 8'h24, 0, 8'h14, 8'h55);
    pend_e = SH ? 5'h0A : 5'h00;
    vecs.push_back(mk(1, 7'h07, 8'hFF, 0, 7'h00, 8'h00, 0, 1, 0, 0, pend_e, act_e));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 1, pend_e, act_e));
    vecs.push_back(mk(1, 7'h44, 8'h77, 0, 7'h00, 8'h00, 0, 1, 0, 0, pend_e, act_e));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 1, pend_e, act_e));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 0, pend_e, act_e));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0, 0, 5'h00,
                      pk(0, 8'h24, 0, 8'h14, 8'h55)));

    // Commit coinciding with a write to the same register keeps the new value pending.
    vecs.push_back(mk(1, 7'h02, 8'h11, 0, 7'h00, 8'h00, 0, 1, 0, 0, 5'h00,
                      pk(0, 8'h24, 0, 8'h14, 8'h55)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 0, SH ? 5'h04 : 5'h00,
                      pk(0, 8'h24, SH ? 8'h00 : 8'h11, 8'h14, 8'h55)));
    vecs.push_back(mk(1, 7'h02, 8'h3C, 0, 7'h00, 8'h00, 0, 1, 0, 0, SH ? 5'h04 : 5'h00,
                      pk(0, 8'h24, SH ? 8'h00 : 8'h11, 8'h14, 8'h55)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0, 0, SH ? 5'h04 : 5'h00,
                      pk(0, 8'h24, SH ? 8'h11 : 8'h3C, 8'h14, 8'h55)));
    vecs.push_back(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0, 0, 5'h00,
                      pk(0, 8'h24, 8'h3C, 8'h14, 8'h55)));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset active", 64'({r4, r3, r2, r1, r0}), 64'h0);
    chk("reset pending", 64'(pending), 64'h0);
    chk("reset err_addr", 64'(err_addr), 64'h0);
    chk("reset a_ready", 64'(bus.a_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single A write to duty cycle, then commit.
    apply(mk(1, 7'h04, 8'h80, 0, 7'h00, 8'h00, 0, 1, 0, 0, 5'h00, 40'h0), 900);
    apply(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0, 0, SH ? 5'h10 : 5'h00,
             SH ? 40'h0 : pk(8'h80, 0, 0, 0, 0)), 901);
    apply(mk(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0, 0, 5'h00, pk(8'h80, 0, 0, 0, 0)), 902);

    // Re-reset so the tie table starts with the pointer at B.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rereset active", 64'({r4, r3, r2, r1, r0}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Reset asserted during the WR cycle: everything clears at once and the write is lost.
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_addr = 7'h04; bus.a_data = 8'h99;
    #1;
    chk("rstwr a_ready", 64'(bus.a_ready), 64'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwr active", 64'({r4, r3, r2, r1, r0}), 64'h0);
    chk("rstwr pending", 64'(pending), 64'h0);
    chk("rstwr a_ready", 64'(bus.a_ready), 64'h0);
    chk("rstwr b_ready", 64'(bus.b_ready), 64'h0);
    bus.a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    commit_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstwr lost active", 64'({r4, r3, r2, r1, r0}), 64'h0);
    chk("rstwr lost pending", 64'(pending), 64'h0);
    chk("rstwr lost err", 64'(err_addr), 64'h0);
    commit_strobe = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
